pipeline_controller: RTL and testbench

Central sequencer for the five-stage pipeline: generates the PC enable and the per-register enable/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves instruction/data memory wait, load-use stall, EX-stage branch/jump redirect and halt drain. It complements the operand-forwarding logic by covering the one hazard forwarding cannot (load result needed by the next instruction). It also keeps saturating stall/flush performance counters.

---
 rtl/pipeline_controller.sv | 141 ++++++++++++++
 tb/tb_pipeline_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Central hazard sequencer for the five-stage pipeline: PC/pipeline-register enables and flushes,
// load-use stall, memory wait freeze, EX redirect squash, halt drain and saturating perf counters.
module pipeline_controller (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmemREN_o3,
    input  logic        dmemWEN_o3,
    input  logic        dmemREN_o2,
    input  logic [4:0]  wsel_o2,
    input  logic [4:0]  rsel1_o1,
    input  logic [4:0]  rsel2_o1,
    input  logic        usesrs_o1,
    input  logic        usesrt_o1,
    input  logic        redirect_o2,
    input  logic        halt_o3,
    output logic        pc_en,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        en_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        halt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LUSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic advance;
    logic lu;
    logic redirect_evt;

    assign advance = ihit & ~((dmemREN_o3 | dmemWEN_o3) & ~dhit);

    assign lu = dmemREN_o2 & (wsel_o2 != 5'd0) &
                ((usesrs_o1 & (wsel_o2 == rsel1_o1)) |
                 (usesrt_o1 & (wsel_o2 == rsel2_o1)));

    // NOTE: every output and next-state term gets a default first so no path leaves a latch.
    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        en_ifid      = 1'b0;
        en_idex      = 1'b0;
        en_exmem     = 1'b0;
        en_memwb     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        halt         = 1'b0;
        redirect_evt = 1'b0;

        if (!RST) begin
            unique case (state_q)
                RUN, LUSTALL: begin
                    if (advance) begin
                        if (halt_o3) begin
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                            flush_ifid = 1'b1;
                            flush_idex = 1'b1;
                            state_d    = DRAIN;
                        end else if (state_q == RUN && redirect_o2) begin
                            pc_en        = 1'b1;
                            en_ifid      = 1'b1;
                            en_idex      = 1'b1;
                            en_exmem     = 1'b1;
                            en_memwb     = 1'b1;
                            flush_ifid   = 1'b1;
                            flush_idex   = 1'b1;
                            redirect_evt = 1'b1;
                            state_d      = RUN;
                        end else if (state_q == RUN && lu) begin
                            // Hold PC and IF/ID, insert one bubble into EX.
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                            flush_idex = 1'b1;
                            state_d    = LUSTALL;
                        end else begin
                            pc_en    = 1'b1;
                            en_ifid  = 1'b1;
                            en_idex  = 1'b1;
                            en_exmem = 1'b1;
                            en_memwb = 1'b1;
                            state_d  = RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        en_memwb   = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = HALTED;
                    end
                end
                HALTED: begin
                    halt = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && state_q != HALTED && !RST && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (redirect_evt && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed hazard scenarios plus random stimulus
// compared each cycle against a flag-based behavioural model of the sequencing rules.
module tb_pipeline_controller;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dmemREN_o3, dmemWEN_o3, dmemREN_o2;
    logic [4:0]  wsel_o2, rsel1_o1, rsel2_o1;
    logic        usesrs_o1, usesrt_o1, redirect_o2, halt_o3;
    logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halt;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pipeline mode as independent flags and integer counters.
    bit m_halted, m_draining, m_bubble_done;
    int m_stalls, m_flushes;

    pipeline_controller dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_o3(dmemREN_o3), .dmemWEN_o3(dmemWEN_o3), .dmemREN_o2(dmemREN_o2),
        .wsel_o2(wsel_o2), .rsel1_o1(rsel1_o1), .rsel2_o1(rsel2_o1),
        .usesrs_o1(usesrs_o1), .usesrt_o1(usesrt_o1),
        .redirect_o2(redirect_o2), .halt_o3(halt_o3),
        .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
        .en_memwb(en_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit ih, input bit dh, input bit r3, input bit w3,
                         input bit r2, input int ws, input int s1, input int s2,
                         input bit u1, input bit u2, input bit rd, input bit h3);
        RST = rst; ihit = ih; dhit = dh; dmemREN_o3 = r3; dmemWEN_o3 = w3;
        dmemREN_o2 = r2; wsel_o2 = 5'(ws); rsel1_o1 = 5'(s1); rsel2_o1 = 5'(s2);
        usesrs_o1 = u1; usesrt_o1 = u2; redirect_o2 = rd; halt_o3 = h3;
    endtask

    task automatic idle_inputs();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: inputs are set before the call (after negedge), outputs checked, model stepped.
    task automatic step();
        bit adv, hazard, is_redirect;
        logic [7:0] exp;
        logic [7:0] got;
        #1;
        adv = ihit && !((dmemREN_o3 || dmemWEN_o3) && !dhit);
        hazard = dmemREN_o2 && wsel_o2 != 0 &&
                 ((usesrs_o1 && wsel_o2 == rsel1_o1) || (usesrt_o1 && wsel_o2 == rsel2_o1));
        is_redirect = 0;
        // exp = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halt}
        if (RST)                  exp = 8'b0000_0000;
        else if (m_halted)        exp = 8'b0000_0001;
        else if (!adv)            exp = 8'b0000_0000;
        else if (m_draining)      exp = 8'b0000_1110;
        else if (halt_o3)         exp = 8'b0001_1110;
        else if (!m_bubble_done && redirect_o2) begin
            exp = 8'b1111_1110;
            is_redirect = 1;
        end
        else if (!m_bubble_done && hazard) exp = 8'b0001_1010;
        else                      exp = 8'b1111_1000;
        got = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, halt};
        check("controls", {8'h00, got}, {8'h00, exp});
        check("stall_cnt", stall_cnt, 16'(m_stalls));
        check("flush_cnt", flush_cnt, 16'(m_flushes));
        @(posedge CLK);
        if (RST) begin
            m_halted = 0; m_draining = 0; m_bubble_done = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (!exp[7] && !m_halted && m_stalls < 65535) m_stalls++;
            if (is_redirect && m_flushes < 65535) m_flushes++;
            if (!m_halted && adv) begin
                if (m_draining) begin
                    m_draining = 0; m_halted = 1;
                end else if (halt_o3) begin
                    m_draining = 1; m_bubble_done = 0;
                end else if (!m_bubble_done && !redirect_o2 && hazard) begin
                    m_bubble_done = 1;
                end else begin
                    m_bubble_done = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 1, 0, 1, 3, 3, 0, 1, 0, 1, 1);
        step();
    endtask

    initial begin
        m_halted = 0; m_draining = 0; m_bubble_done = 0; m_stalls = 0; m_flushes = 0;
        idle_inputs();
        RST = 1;
        @(negedge CLK);

        // Reset cycle outputs are all quiet regardless of inputs.
        do_reset();
        check("reset_halt", {15'd0, halt}, 16'd0);
        idle_inputs(); step();

        // Load-use on rs: one bubble then run.
        drive(0, 1, 1, 0, 0, 1, 3, 3, 7, 1, 0, 0, 0); step();
        idle_inputs(); step();
        check("lu_stall_cnt", stall_cnt, 16'd1);
        // Same pair with $0 destination: no stall.
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        #1 check("lu_r0_pc_en", {15'd0, pc_en}, 16'd1);
        step();
        // Load-use on rt while the hazard persists during the bubble cycle.
        drive(0, 1, 1, 0, 0, 1, 9, 1, 9, 0, 1, 0, 0); step(); step();
        idle_inputs(); step();
        check("lu_rt_stall_cnt", stall_cnt, 16'd2);

        // Data memory wait for 3 cycles.
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("dwait_stall_cnt", stall_cnt, 16'd5);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("dwait_release", {11'd0, pc_en, en_ifid, en_idex, en_exmem, en_memwb}, 16'h1F);
        step();

        // Miss extends LUSTALL without losing the release cycle.
        drive(0, 1, 1, 0, 0, 1, 4, 4, 0, 1, 0, 0, 0); step();
        drive(0, 1, 0, 0, 1, 1, 4, 4, 0, 1, 0, 0, 0); step(); step();
        drive(0, 1, 1, 0, 0, 1, 4, 4, 0, 1, 0, 0, 0);
        #1 check("lustall_release_pc_en", {15'd0, pc_en}, 16'd1);
        step();

        // Redirect together with load-use: squash, no stall.
        drive(0, 1, 1, 0, 0, 1, 5, 5, 0, 1, 0, 1, 0);
        #1 check("redir_lu_flushes", {14'd0, flush_ifid, flush_idex}, 16'd3);
        step();
        check("redir_flush_cnt", flush_cnt, 16'd1);
        idle_inputs(); step();

        // Halt drain, with a miss stretching DRAIN.
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        idle_inputs();
        #1 check("drain_memwb_only", {11'd0, pc_en, en_ifid, en_idex, en_exmem, en_memwb}, 16'h01);
        step();
        check("halted_flag", {15'd0, halt}, 16'd1);
        for (int i = 0; i < 6; i++) begin
            drive(0, i[0], 1, 0, 0, 0, 0, 0, 0, 0, 0, i[1], i[2]);
            step();
        end
        check("halted_stall_frozen", stall_cnt, 16'(m_stalls));

        // Reset while in LUSTALL with a pending data miss.
        do_reset();
        drive(0, 1, 1, 0, 0, 1, 6, 0, 6, 0, 1, 0, 0); step();
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("rst_lu_stall_cnt", stall_cnt, 16'd0);
        check("rst_lu_halt", {15'd0, halt}, 16'd0);
        idle_inputs();
        #1 check("rst_lu_run", {15'd0, pc_en}, 16'd1);
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  !m_bubble_done && $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
            step();
        end

        // Stall counter saturation.
        do_reset();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (70000) step();
        check("stall_saturated", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
